packed_array_regfile: RTL and testbench
=======================================

// Module: packed_array_regfile
// PURPOSE
//  Clocked 3-D packed-array store: mem[ROWS][COLS][W], reset-loaded from a
//  packed INIT constant. Provides one handshaked element-write port, NRD
//  independent registered read ports, and a multi-cycle row-copy engine.
//  Drop-in state holder for blocks that previously used constant packed arrays.
// PARAMETERS
//  ROWS  2          number of rows (outer packed dimension)
//  COLS  3          elements per row (middle packed dimension)
//  W     4          element width in bits
//  NRD   2          number of read ports
//  INIT  24'h6E56E5 reset image, ROWS*COLS*W bits; mem[r][c] = INIT[(r*COLS+c)*W +: W]
//  Derived: RW = (ROWS>1) ? $clog2(ROWS) : 1;  CW = (COLS>1) ? $clog2(COLS) : 1
// PORTS
//  clk       in   1             clock, rising edge
//  rst_n     in   1             asynchronous active-low reset
//  wr_valid  in   1             element write request
//  wr_ready  out  1             write accepted when wr_valid & wr_ready
//  wr_row    in   RW            write row index
//  wr_col    in   CW            write column index
//  wr_data   in   W             write data
//  rd_en     in   NRD           per-port read strobe
//  rd_row    in   [NRD][RW]     per-port row index
//  rd_col    in   [NRD][CW]     per-port column index
//  rd_data   out  [NRD][W]      registered read data
//  rd_valid  out  NRD           rd_data[i] valid this cycle
//  cp_valid  in   1             row-copy request
//  cp_ready  out  1             copy accepted when cp_valid & cp_ready
//  cp_src    in   RW            source row
//  cp_dst    in   RW            destination row
//  cp_done   out  1             one-cycle pulse, copy finished
//  err       out  1             one-cycle pulse, out-of-range index on an accepted op
//  mem_q     out  [ROWS][COLS][W]  full array, current register contents
// BEHAVIOUR
//  Reset (async assert, sync release): mem <= INIT; rd_data 0; rd_valid 0;
//   cp_done 0; err 0; state IDLE; column counter 0. Asserted mid-copy: copy aborts, no partial state kept.
//  FSM: IDLE -> COPY on cp_valid & cp_ready (valid indices);
//   COPY: mem[dst][k] <= mem[src][k], k = 0..COLS-1, one element/cycle;
//   k == COLS-1 -> DONE; DONE: cp_done = 1 for one cycle -> IDLE.
//   Copy latency: accept edge + COLS cycles + 1 DONE cycle.
//  cp_ready = (state == IDLE). wr_ready = (state == IDLE) & !cp_valid
//   (copy wins a simultaneous request; write must be held and retried).
//  Write: mem[wr_row][wr_col] <= wr_data on the accept edge; visible on mem_q
//   and to reads issued the following cycle.
//  Read: rd_en[i] sampled at edge N -> rd_data[i]/rd_valid[i] valid after edge N
//   (1-cycle latency). Same-cycle read and write of the same element returns OLD value.
//   Reads are allowed in every state, including COPY, and return pre-edge contents.
//   rd_data[i] holds its last value when rd_en[i] = 0; rd_valid[i] = 0.
//  Range: row >= ROWS or col >= COLS (non-power-of-2 sizes) ->
//   write: accepted, dropped, err pulse; read: rd_data 0, rd_valid 1, err pulse;
//   copy: accepted, no FSM transition, err pulse. Multiple sources OR into one err.
//  cp_src == cp_dst: legal; runs full COLS cycles; contents unchanged.
//  mem_q is the register image directly, no extra latency.
// TESTING
//  T1 reset: release rst_n -> mem_q == 24'h6E56E5; mem[0][0]=5, [0][1]=E, [1][2]=6.
//  T2 read: rd_en=2'b11, port0 (0,1), port1 (1,0) -> next cycle rd_data = {5, E}, rd_valid = 11.
//  T3 write+read same element: wr (1,2)=9 with rd (1,2) -> read returns 6; next read returns 9.
//  T4 copy: write (0,0)=A, then cp 0->1 -> wr_ready 0 for 4 cycles; cp_done pulse;
//     mem row1 = {6,E,A} (c2..c0).
//  T5 range (ROWS=3): wr_row=3 -> err pulse, mem_q unchanged; rd row 3 -> rd_data 0, err 1.
//  T6 reset mid-copy: drop rst_n in COPY k=1 -> mem_q == INIT, cp_ready 1 after release.

Source files
------------

// File: rtl/packed_array_regfile.sv
// Register-based 3-D packed array with a handshaked element write port, NRD registered read ports
// and a one-element-per-cycle row-copy engine. The full contents are exported on mem_q.
module packed_array_regfile #(
    parameter int ROWS = 2,
    parameter int COLS = 3,
    parameter int W    = 4,
    parameter int NRD  = 2,
    parameter logic [ROWS*COLS*W-1:0] INIT = 24'h6E56E5,
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             wr_valid,
    output logic                             wr_ready,
    input  logic [RW-1:0]                    wr_row,
    input  logic [CW-1:0]                    wr_col,
    input  logic [W-1:0]                     wr_data,
    input  logic [NRD-1:0]                   rd_en,
    input  logic [NRD-1:0][RW-1:0]           rd_row,
    input  logic [NRD-1:0][CW-1:0]           rd_col,
    output logic [NRD-1:0][W-1:0]            rd_data,
    output logic [NRD-1:0]                   rd_valid,
    input  logic                             cp_valid,
    output logic                             cp_ready,
    input  logic [RW-1:0]                    cp_src,
    input  logic [RW-1:0]                    cp_dst,
    output logic                             cp_done,
    output logic                             err,
    output logic [ROWS-1:0][COLS-1:0][W-1:0] mem_q
);

    typedef enum logic [1:0] {IDLE, COPY, DONE} state_t;

    state_t                          state_reg, state_next;
    logic [ROWS-1:0][COLS-1:0][W-1:0] mem_reg;
    logic [CW-1:0]                   k_reg;
    logic [RW-1:0]                   src_reg, dst_reg;
    logic [NRD-1:0][W-1:0]           rd_data_reg;
    logic [NRD-1:0]                  rd_valid_reg;
    logic                            err_reg;

    logic                            wr_fire, wr_oor, cp_fire, cp_oor;
    logic [NRD-1:0]                  rd_oor;

    function automatic logic row_oor(input logic [RW-1:0] r);
        return 32'(r) >= 32'(ROWS);
    endfunction

    function automatic logic col_oor(input logic [CW-1:0] c);
        return 32'(c) >= 32'(COLS);
    endfunction

    // Only reachable with non-power-of-2 ROWS/COLS; otherwise these fold to constant 0.
    assign wr_oor  = row_oor(wr_row) | col_oor(wr_col);
    assign cp_oor  = row_oor(cp_src) | row_oor(cp_dst);

    generate
        for (genvar gi = 0; gi < NRD; gi++) begin : g_rd_range
            assign rd_oor[gi] = row_oor(rd_row[gi]) | col_oor(rd_col[gi]);
        end
    endgenerate

    assign cp_ready = (state_reg == IDLE);
    assign wr_ready = (state_reg == IDLE) & ~cp_valid;
    assign cp_done  = (state_reg == DONE);
    assign wr_fire  = wr_valid & wr_ready;
    assign cp_fire  = cp_valid & cp_ready;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (cp_fire && !cp_oor) state_next = COPY;
            COPY:    if (k_reg == CW'(COLS - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_reg      <= INIT;
            state_reg    <= IDLE;
            k_reg        <= '0;
            src_reg      <= '0;
            dst_reg      <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= '0;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (cp_fire && !cp_oor) begin
                src_reg <= cp_src;
                dst_reg <= cp_dst;
                k_reg   <= '0;
            end else if (state_reg == COPY) begin
                mem_reg[dst_reg][k_reg] <= mem_reg[src_reg][k_reg];
                k_reg                   <= k_reg + 1'b1;
            end
            // Writes are only accepted in IDLE, so they never collide with the copy engine.
            if (wr_fire && !wr_oor)
                mem_reg[wr_row][wr_col] <= wr_data;
            for (int i = 0; i < NRD; i++) begin
                rd_valid_reg[i] <= rd_en[i];
                if (rd_en[i])
                    rd_data_reg[i] <= rd_oor[i] ? '0 : mem_reg[rd_row[i]][rd_col[i]];
            end
            err_reg <= (wr_fire & wr_oor) | (cp_fire & cp_oor) | (|(rd_en & rd_oor));
        end
    end

    assign rd_data  = rd_data_reg;
    assign rd_valid = rd_valid_reg;
    assign err      = err_reg;
    assign mem_q    = mem_reg;

endmodule

// File: tb/tb_packed_array_regfile.sv
// Directed bench for packed_array_regfile: default 2x3 instance plus a 3x3 instance for range errors.
module tb_packed_array_regfile;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n;

    // ---------------- instance 1: ROWS=2 COLS=3 W=4 NRD=2 ----------------
    logic                  wr_valid, wr_ready, cp_valid, cp_ready, cp_done, err;
    logic [0:0]            wr_row, cp_src, cp_dst;
    logic [1:0]            wr_col;
    logic [3:0]            wr_data;
    logic [1:0]            rd_en, rd_valid;
    logic [1:0][0:0]       rd_row;
    logic [1:0][1:0]       rd_col;
    logic [1:0][3:0]       rd_data;
    logic [1:0][2:0][3:0]  mem_q;

    packed_array_regfile dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
        .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data), .rd_valid(rd_valid),
        .cp_valid(cp_valid), .cp_ready(cp_ready), .cp_src(cp_src), .cp_dst(cp_dst), .cp_done(cp_done),
        .err(err), .mem_q(mem_q)
    );

    // ---------------- instance 2: ROWS=3 COLS=3 W=4 NRD=1 ----------------
    logic                  w2_valid, w2_ready, c2_valid, c2_ready, c2_done, err2;
    logic [1:0]            w2_row, w2_col, c2_src, c2_dst;
    logic [3:0]            w2_data;
    logic [0:0]            r2_en, r2_valid;
    logic [0:0][1:0]       r2_row, r2_col;
    logic [0:0][3:0]       r2_data;
    logic [2:0][2:0][3:0]  mem_q2;

    packed_array_regfile #(.ROWS(3), .COLS(3), .W(4), .NRD(1), .INIT(36'h123456789)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(w2_valid), .wr_ready(w2_ready), .wr_row(w2_row), .wr_col(w2_col), .wr_data(w2_data),
        .rd_en(r2_en), .rd_row(r2_row), .rd_col(r2_col), .rd_data(r2_data), .rd_valid(r2_valid),
        .cp_valid(c2_valid), .cp_ready(c2_ready), .cp_src(c2_src), .cp_dst(c2_dst), .cp_done(c2_done),
        .err(err2), .mem_q(mem_q2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        wr_valid = 0; wr_row = '0; wr_col = '0; wr_data = '0;
        rd_en = '0; rd_row = '0; rd_col = '0;
        cp_valid = 0; cp_src = '0; cp_dst = '0;
        w2_valid = 0; w2_row = '0; w2_col = '0; w2_data = '0;
        r2_en = '0; r2_row = '0; r2_col = '0;
        c2_valid = 0; c2_src = '0; c2_dst = '0;

        // T1 reset
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (mem_q !== 24'h6E56E5) begin n_err++; $display("FAIL rst_mem_q: got %0h", mem_q); end
        n_cmp++; if (rd_valid !== 2'b00) begin n_err++; $display("FAIL rst_rd_valid: got %0h", rd_valid); end
        n_cmp++; if (rd_data !== 8'h00) begin n_err++; $display("FAIL rst_rd_data: got %0h", rd_data); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0h", err); end
        n_cmp++; if (cp_done !== 1'b0) begin n_err++; $display("FAIL rst_cp_done: got %0h", cp_done); end
        rst_n = 1'b1;
        tick();
        n_cmp++; if (mem_q !== 24'h6E56E5) begin n_err++; $display("FAIL t1_mem_q: got %0h", mem_q); end
        n_cmp++; if (mem_q[0][0] !== 4'h5) begin n_err++; $display("FAIL t1_m00: got %0h", mem_q[0][0]); end
        n_cmp++; if (mem_q[0][1] !== 4'hE) begin n_err++; $display("FAIL t1_m01: got %0h", mem_q[0][1]); end
        n_cmp++; if (mem_q[1][2] !== 4'h6) begin n_err++; $display("FAIL t1_m12: got %0h", mem_q[1][2]); end
        n_cmp++; if (cp_ready !== 1'b1) begin n_err++; $display("FAIL t1_cp_ready: got %0h", cp_ready); end
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL t1_wr_ready: got %0h", wr_ready); end
        n_cmp++; if (mem_q2 !== 36'h123456789) begin n_err++; $display("FAIL t1_mem_q2: got %0h", mem_q2); end
        $display("T1 reset done");

        // T2 dual read
        rd_en = 2'b11; rd_row[0] = 1'b0; rd_col[0] = 2'd1; rd_row[1] = 1'b1; rd_col[1] = 2'd0;
        tick();
        n_cmp++; if (rd_data !== 8'h5E) begin n_err++; $display("FAIL t2_rd_data: got %0h", rd_data); end
        n_cmp++; if (rd_valid !== 2'b11) begin n_err++; $display("FAIL t2_rd_valid: got %0h", rd_valid); end
        n_cmp++; if (err !== 1'b0) begin n_err++; $display("FAIL t2_err: got %0h", err); end
        rd_en = 2'b00;
        tick();
        n_cmp++; if (rd_valid !== 2'b00) begin n_err++; $display("FAIL t2_hold_valid: got %0h", rd_valid); end
        n_cmp++; if (rd_data !== 8'h5E) begin n_err++; $display("FAIL t2_hold_data: got %0h", rd_data); end
        $display("T2 read (0,1),(1,0)");

        // T3 write and read same element
        wr_valid = 1; wr_row = 1'b1; wr_col = 2'd2; wr_data = 4'h9;
        rd_en = 2'b01; rd_row[0] = 1'b1; rd_col[0] = 2'd2;
        tick();
        n_cmp++; if (rd_data[0] !== 4'h6) begin n_err++; $display("FAIL t3_old: got %0h", rd_data[0]); end
        n_cmp++; if (mem_q[1][2] !== 4'h9) begin n_err++; $display("FAIL t3_mem: got %0h", mem_q[1][2]); end
        wr_valid = 0;
        tick();
        n_cmp++; if (rd_data[0] !== 4'h9) begin n_err++; $display("FAIL t3_new: got %0h", rd_data[0]); end
        rd_en = 2'b00;
        $display("T3 write (1,2)=9 with same-cycle read");

        // T4 write (0,0)=A then copy row 0 -> row 1
        wr_valid = 1; wr_row = 1'b0; wr_col = 2'd0; wr_data = 4'hA;
        tick();
        wr_valid = 0;
        n_cmp++; if (mem_q[0][0] !== 4'hA) begin n_err++; $display("FAIL t4_wr: got %0h", mem_q[0][0]); end
        cp_valid = 1; cp_src = 1'b0; cp_dst = 1'b1;
        #1;
        n_cmp++; if (cp_ready !== 1'b1) begin n_err++; $display("FAIL t4_cp_ready: got %0h", cp_ready); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL t4_wr_block: got %0h", wr_ready); end
        tick();
        cp_valid = 0;
        #1;
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL t4_c0_wr_ready: got %0h", wr_ready); end
        n_cmp++; if (cp_ready !== 1'b0) begin n_err++; $display("FAIL t4_c0_cp_ready: got %0h", cp_ready); end
        rd_en = 2'b01; rd_row[0] = 1'b1; rd_col[0] = 2'd0;
        tick();
        rd_en = 2'b00;
        n_cmp++; if (rd_data[0] !== 4'h5) begin n_err++; $display("FAIL t4_rd_during_copy: got %0h", rd_data[0]); end
        n_cmp++; if (mem_q[1][0] !== 4'hA) begin n_err++; $display("FAIL t4_m10_copied: got %0h", mem_q[1][0]); end
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL t4_c1_wr_ready: got %0h", wr_ready); end
        n_cmp++; if (cp_done !== 1'b0) begin n_err++; $display("FAIL t4_c1_done: got %0h", cp_done); end
        tick();
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL t4_c2_wr_ready: got %0h", wr_ready); end
        n_cmp++; if (cp_done !== 1'b0) begin n_err++; $display("FAIL t4_c2_done: got %0h", cp_done); end
        tick();
        n_cmp++; if (wr_ready !== 1'b0) begin n_err++; $display("FAIL t4_c3_wr_ready: got %0h", wr_ready); end
        n_cmp++; if (cp_done !== 1'b1) begin n_err++; $display("FAIL t4_c3_done: got %0h", cp_done); end
        tick();
        n_cmp++; if (wr_ready !== 1'b1) begin n_err++; $display("FAIL t4_idle_wr_ready: got %0h", wr_ready); end
        n_cmp++; if (cp_done !== 1'b0) begin n_err++; $display("FAIL t4_idle_done: got %0h", cp_done); end
        n_cmp++; if (mem_q[1] !== 12'h6EA) begin n_err++; $display("FAIL t4_row1: got %0h", mem_q[1]); end
        n_cmp++; if (mem_q[0] !== 12'h6EA) begin n_err++; $display("FAIL t4_row0: got %0h", mem_q[0]); end
        $display("T4 copy row0->row1");

        // self-copy of row 1 after making it distinct
        wr_valid = 1; wr_row = 1'b1; wr_col = 2'd1; wr_data = 4'h3;
        tick();
        wr_valid = 0;
        cp_valid = 1; cp_src = 1'b1; cp_dst = 1'b1;
        tick();
        cp_valid = 0;
        n = 0;
        while (!cp_done && n < 10) begin
            tick();
            n++;
        end
        n_cmp++; if (n !== 3) begin n_err++; $display("FAIL self_latency: got %0d", n); end
        tick();
        n_cmp++; if (mem_q[1] !== 12'h63A) begin n_err++; $display("FAIL self_row1: got %0h", mem_q[1]); end
        n_cmp++; if (cp_ready !== 1'b1) begin n_err++; $display("FAIL self_idle: got %0h", cp_ready); end
        $display("self-copy row1->row1");

        // T5 range errors on the 3x3 instance
        r2_en = 1'b1; r2_row[0] = 2'd0; r2_col[0] = 2'd0;
        tick();
        n_cmp++; if (r2_data[0] !== 4'h9) begin n_err++; $display("FAIL t5_rd_ok: got %0h", r2_data[0]); end
        n_cmp++; if (err2 !== 1'b0) begin n_err++; $display("FAIL t5_rd_ok_err: got %0h", err2); end
        w2_valid = 1; w2_row = 2'd3; w2_col = 2'd0; w2_data = 4'hF;
        r2_row[0] = 2'd3; r2_col[0] = 2'd1;
        tick();
        w2_valid = 0; r2_en = 1'b0;
        n_cmp++; if (err2 !== 1'b1) begin n_err++; $display("FAIL t5_err_pulse: got %0h", err2); end
        n_cmp++; if (r2_data[0] !== 4'h0) begin n_err++; $display("FAIL t5_rd_zero: got %0h", r2_data[0]); end
        n_cmp++; if (r2_valid !== 1'b1) begin n_err++; $display("FAIL t5_rd_valid: got %0h", r2_valid); end
        n_cmp++; if (mem_q2 !== 36'h123456789) begin n_err++; $display("FAIL t5_mem_unch: got %0h", mem_q2); end
        tick();
        n_cmp++; if (err2 !== 1'b0) begin n_err++; $display("FAIL t5_err_clear: got %0h", err2); end
        c2_valid = 1; c2_src = 2'd3; c2_dst = 2'd0;
        #1;
        n_cmp++; if (c2_ready !== 1'b1) begin n_err++; $display("FAIL t5_cp_ready: got %0h", c2_ready); end
        tick();
        c2_valid = 0;
        n_cmp++; if (err2 !== 1'b1) begin n_err++; $display("FAIL t5_cp_err: got %0h", err2); end
        n_cmp++; if (c2_ready !== 1'b1) begin n_err++; $display("FAIL t5_cp_no_fsm: got %0h", c2_ready); end
        tick();
        n_cmp++; if (c2_done !== 1'b0) begin n_err++; $display("FAIL t5_cp_no_done: got %0h", c2_done); end
        w2_valid = 1; w2_row = 2'd0; w2_col = 2'd3; w2_data = 4'hF;
        tick();
        n_cmp++; if (err2 !== 1'b1) begin n_err++; $display("FAIL t5_col_err: got %0h", err2); end
        n_cmp++; if (mem_q2 !== 36'h123456789) begin n_err++; $display("FAIL t5_col_mem: got %0h", mem_q2); end
        w2_row = 2'd2; w2_col = 2'd2; w2_data = 4'h0;
        tick();
        w2_valid = 0;
        n_cmp++; if (mem_q2 !== 36'h023456789) begin n_err++; $display("FAIL t5_valid_wr: got %0h", mem_q2); end
        n_cmp++; if (err2 !== 1'b0) begin n_err++; $display("FAIL t5_valid_wr_err: got %0h", err2); end
        $display("T5 range errors on 3x3");

        // T6 reset in the middle of a copy
        cp_valid = 1; cp_src = 1'b0; cp_dst = 1'b1;
        tick();
        cp_valid = 0;
        tick();
        n_cmp++; if (cp_ready !== 1'b0) begin n_err++; $display("FAIL t6_in_copy: got %0h", cp_ready); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_q !== 24'h6E56E5) begin n_err++; $display("FAIL t6_mem_init: got %0h", mem_q); end
        n_cmp++; if (cp_ready !== 1'b1) begin n_err++; $display("FAIL t6_cp_ready: got %0h", cp_ready); end
        tick();
        rst_n = 1'b1;
        tick();
        n_cmp++; if (cp_ready !== 1'b1) begin n_err++; $display("FAIL t6_post_ready: got %0h", cp_ready); end
        n_cmp++; if (cp_done !== 1'b0) begin n_err++; $display("FAIL t6_post_done: got %0h", cp_done); end
        n_cmp++; if (mem_q !== 24'h6E56E5) begin n_err++; $display("FAIL t6_post_mem: got %0h", mem_q); end
        $display("T6 reset mid-copy");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
